// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store unit.
// Holds RV32I width codes and the LSU state encoding.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    // Stores only know B/H/W; loads add the unsigned B/H forms.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        if (!we) begin
            ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
        end
        return ok;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Read-data extraction for loads: lane select plus extension.
// Purely combinational so a cache fill path can share it.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rd,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata
);

    logic [31:0] lane;

    assign lane = rd >> {addr, 3'b000};

    // Extend the selected lane according to width and signedness.
    always_comb begin
        rdata = lane;
        case (funct3)
            F3_B:    rdata = {{24{lane[7]}}, lane[7:0]};
            F3_H:    rdata = {{16{lane[15]}}, lane[15:0]};
            F3_BU:   rdata = {24'b0, lane[7:0]};
            F3_HU:   rdata = {16'b0, lane[15:0]};
            default: rdata = lane;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit between execute and a word-wide data memory.
// Handles lane steering, strobes, errors and load formatting.
module lsu
    import lsu_pkg::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_re,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    state_t      state;
    state_t      state_nx;
    logic [31:0] lat_addr;
    logic [2:0]  lat_f3;
    logic        lat_en;
    logic        accept;
    logic        misal;
    logic        is_err;
    logic [3:0]  strb;
    logic [31:0] wd;
    logic [1:0]  fmt_addr;
    logic [2:0]  fmt_f3;
    logic [31:0] fmt_data;
    logic        rsp_valid_nx;
    logic        rsp_err_nx;
    logic [31:0] rsp_rdata_nx;

    assign req_ready = (state == IDLE) & ~reset;
    assign accept    = req_valid & req_ready;

    assign misal  = ((req_funct3[1:0] == 2'b01) & req_addr[0])
                  | ((req_funct3[1:0] == 2'b10) & (|req_addr[1:0]));
    assign is_err = ~f3_legal(req_we, req_funct3) | misal;

    // Store lane replication and byte strobes from width and offset.
    always_comb begin
        strb = 4'b1111;
        wd   = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                strb = 4'b0001 << req_addr[1:0];
                wd   = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                strb = 4'b0011 << {req_addr[1], 1'b0};
                wd   = {2{req_wdata[15:0]}};
            end
            default: begin
                strb = 4'b1111;
                wd   = req_wdata;
            end
        endcase
    end

    assign fmt_addr = (state == WAIT) ? lat_addr[1:0] : req_addr[1:0];
    assign fmt_f3   = (state == WAIT) ? lat_f3 : req_funct3;

    lsu_load_align u_align (
        .rd     (mem_rd),
        .addr   (fmt_addr),
        .funct3 (fmt_f3),
        .rdata  (fmt_data)
    );

    // Next state, memory controls and next response values.
    always_comb begin
        state_nx     = state;
        mem_re       = 1'b0;
        mem_wstrb    = 4'b0000;
        mem_a        = req_addr;
        mem_wd       = wd;
        lat_en       = 1'b0;
        rsp_valid_nx = 1'b0;
        rsp_err_nx   = 1'b0;
        rsp_rdata_nx = rsp_rdata;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (is_err) begin
                        rsp_valid_nx = 1'b1;
                        rsp_err_nx   = 1'b1;
                        rsp_rdata_nx = 32'h0;
                    end else if (req_we) begin
                        mem_wstrb    = strb;
                        rsp_valid_nx = 1'b1;
                        rsp_rdata_nx = 32'h0;
                    end else begin
                        mem_re = 1'b1;
                        if (READ_LATENCY == 0) begin
                            rsp_valid_nx = 1'b1;
                            rsp_rdata_nx = fmt_data;
                        end else begin
                            state_nx = WAIT;
                            lat_en   = 1'b1;
                        end
                    end
                end
            end
            WAIT: begin
                mem_re       = 1'b1;
                mem_a        = lat_addr;
                state_nx     = IDLE;
                rsp_valid_nx = 1'b1;
                rsp_rdata_nx = fmt_data;
            end
            default: state_nx = IDLE;
        endcase
        if (reset) begin
            mem_re    = 1'b0;
            mem_wstrb = 4'b0000;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Hold the load address and width for the wait-state read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_addr <= 32'h0;
            lat_f3   <= 3'b000;
        end else if (lat_en) begin
            lat_addr <= req_addr;
            lat_f3   <= req_funct3;
        end
    end

    // Response registers; reset drops any pending response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'h0;
        end else begin
            rsp_valid <= rsp_valid_nx;
            rsp_err   <= rsp_err_nx;
            rsp_rdata <= rsp_rdata_nx;
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: one BSRAM-style and one combinational-memory instance.
// Expected responses are queued at issue and matched at rsp_valid.
module tb_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        rv0;
    logic        rv1;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        rdy1, rspv1, rspe1, re1;
    logic [31:0] rspd1, a1, wd1, rd1;
    logic [3:0]  ws1;
    logic        rdy0, rspv0, rspe0, re0;
    logic [31:0] rspd0, a0, wd0, rd0;
    logic [3:0]  ws0;

    typedef struct {
        logic [31:0] d;
        logic        e;
        int          due;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    bit          stall_exp;
    logic [31:0] mem[0:255];
    logic [31:0] ref_mem[0:255];

    lsu #(.READ_LATENCY(1)) dut1 (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (rv1),
        .req_ready  (rdy1),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rspv1),
        .rsp_rdata  (rspd1),
        .rsp_err    (rspe1),
        .mem_re     (re1),
        .mem_wstrb  (ws1),
        .mem_a      (a1),
        .mem_wd     (wd1),
        .mem_rd     (rd1)
    );

    lsu #(.READ_LATENCY(0)) dut0 (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (rv0),
        .req_ready  (rdy0),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rspv0),
        .rsp_rdata  (rspd0),
        .rsp_err    (rspe0),
        .mem_re     (re0),
        .mem_wstrb  (ws0),
        .mem_a      (a0),
        .mem_wd     (wd0),
        .mem_rd     (rd0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (ws1[i]) mem[a1[9:2]][8*i +: 8] <= wd1[8*i +: 8];
            if (ws0[i]) mem[a0[9:2]][8*i +: 8] <= wd0[8*i +: 8];
        end
        if (re1) rd1 <= mem[a1[9:2]];
    end

    assign rd0 = mem[a0[9:2]];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic ref_err(input logic we, input logic [2:0] f3,
                                     input logic [31:0] a);
        logic ok;
        if (we) ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
        else    ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2)
                  || (f3 == 3'd4) || (f3 == 3'd5);
        if (!ok) return 1'b1;
        if ((f3 == 3'd1 || f3 == 3'd5) && a[0]) return 1'b1;
        if (f3 == 3'd2 && a[1:0] != 2'b00) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [3:0] ref_strb(input logic [2:0] f3,
                                            input logic [31:0] a);
        case (f3)
            3'd0:    return 4'b0001 << a[1:0];
            3'd1:    return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] ref_wd(input logic [2:0] f3,
                                           input logic [31:0] w);
        case (f3)
            3'd0:    return {4{w[7:0]}};
            3'd1:    return {2{w[15:0]}};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] fmt(input logic [31:0] w,
                                        input logic [1:0] off,
                                        input logic [2:0] f3);
        logic [31:0] s;
        s = w >> (8 * off);
        case (f3)
            3'd0:    return {{24{s[7]}}, s[7:0]};
            3'd1:    return {{16{s[15]}}, s[15:0]};
            3'd4:    return {24'h0, s[7:0]};
            3'd5:    return {16'h0, s[15:0]};
            default: return s;
        endcase
    endfunction

    always @(negedge clk) begin
        if (rspv1) begin
            exp_t x;
            if (q1.size() == 0) begin
                chk("spurious_rsp1", 32'd1, 32'd0);
            end else begin
                x = q1.pop_front();
                chk("rdata1", rspd1, x.d);
                chk("err1", {31'h0, rspe1}, {31'h0, x.e});
                chk("lat1", cyc, x.due);
            end
        end
    end

    always @(negedge clk) begin
        if (rspv0) begin
            exp_t x;
            if (q0.size() == 0) begin
                chk("spurious_rsp0", 32'd1, 32'd0);
            end else begin
                x = q0.pop_front();
                chk("rdata0", rspd0, x.d);
                chk("err0", {31'h0, rspe0}, {31'h0, x.e});
                chk("lat0", cyc, x.due);
            end
        end
    end

    task automatic issue(input bit s, input bit we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] w);
        int          n;
        logic        err;
        logic        isld;
        logic [3:0]  st;
        logic [31:0] rw;
        exp_t        x;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = w;
        if (s) rv1 = 1'b1;
        else   rv0 = 1'b1;
        n = 0;
        @(negedge clk);
        while (!(s ? rdy1 : rdy0) && n < 8) begin
            n++;
            @(negedge clk);
        end
        chk("stall", n, (s && stall_exp) ? 32'd1 : 32'd0);
        err  = ref_err(we, f3, a);
        isld = !we && !err;
        st   = (we && !err) ? ref_strb(f3, a) : 4'b0000;
        rw   = ref_wd(f3, w);
        chk("acc_re", {31'h0, s ? re1 : re0}, {31'h0, isld});
        chk("acc_wstrb", {28'h0, s ? ws1 : ws0}, {28'h0, st});
        chk("acc_addr", s ? a1 : a0, a);
        x.e   = err;
        x.d   = isld ? fmt(ref_mem[a[9:2]], a[1:0], f3) : 32'h0;
        x.due = cyc + ((isld && s) ? 2 : 1);
        if (we && !err) begin
            chk("acc_wd", s ? wd1 : wd0, rw);
            for (int i = 0; i < 4; i++)
                if (st[i]) ref_mem[a[9:2]][8*i +: 8] = rw[8*i +: 8];
        end
        if (s) q1.push_back(x);
        else   q0.push_back(x);
        @(posedge clk);
        #1;
        rv0 = 1'b0;
        rv1 = 1'b0;
        stall_exp = s && isld;
        if (s && isld) begin
            chk("wait_ready", {31'h0, rdy1}, 32'd0);
            chk("wait_re", {31'h0, re1}, 32'd1);
            chk("wait_wstrb", {28'h0, ws1}, 32'd0);
            chk("wait_addr", a1, a);
        end
    endtask

    task automatic idle(input int k);
        repeat (k) @(posedge clk);
        #1;
        stall_exp = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = (32'h01010101 * i) ^ 32'hA5C30000;
            ref_mem[i] = (32'h01010101 * i) ^ 32'hA5C30000;
        end
        mem[64]     = 32'h80011234;
        ref_mem[64] = 32'h80011234;
        mem[0]      = 32'h7F000000;
        ref_mem[0]  = 32'h7F000000;
        reset      = 1'b1;
        rv0        = 1'b0;
        rv1        = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        stall_exp  = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'h0, rdy1}, 32'd0);
        chk("rst_valid", {31'h0, rspv1}, 32'd0);
        chk("rst_rdata", rspd1, 32'd0);
        chk("rst_err", {31'h0, rspe1}, 32'd0);
        chk("rst_re", {31'h0, re1}, 32'd0);
        chk("rst_wstrb", {28'h0, ws1}, 32'd0);
        reset = 1'b0;
        idle(1);

        issue(1, 0, 3'd1, 32'h102, 32'h0);
        issue(1, 0, 3'd5, 32'h102, 32'h0);
        issue(1, 1, 3'd0, 32'h103, 32'h000000AB);
        issue(1, 0, 3'd2, 32'h101, 32'h0);
        issue(1, 1, 3'd4, 32'h100, 32'h12345678);
        idle(2);

        issue(1, 1, 3'd2, 32'h200, 32'h11223344);
        issue(1, 0, 3'd0, 32'h201, 32'h0);
        issue(1, 1, 3'd2, 32'h204, 32'hCAFEF00D);
        issue(1, 0, 3'd2, 32'h204, 32'h0);
        idle(2);

        issue(1, 0, 3'd2, 32'h200, 32'h0);
        reset = 1'b1;
        q1.delete(q1.size() - 1);
        #1;
        chk("rstw_valid", {31'h0, rspv1}, 32'd0);
        chk("rstw_re", {31'h0, re1}, 32'd0);
        chk("rstw_wstrb", {28'h0, ws1}, 32'd0);
        chk("rstw_ready", {31'h0, rdy1}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        idle(3);
        issue(1, 0, 3'd2, 32'h204, 32'h0);
        idle(2);

        issue(0, 0, 3'd0, 32'h3, 32'h0);
        issue(0, 1, 3'd1, 32'h2, 32'h0000BEEF);
        issue(0, 0, 3'd5, 32'h2, 32'h0);
        issue(0, 0, 3'd1, 32'h3, 32'h0);
        idle(2);

        for (int i = 0; i < 60; i++) begin
            issue(i[0], $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)),
                  32'($urandom_range(0, 1023)), $urandom);
        end

        k = 0;
        while ((q0.size() + q1.size()) != 0 && k < 10) begin
            k++;
            @(posedge clk);
        end
        #1;
        chk("drain", q0.size() + q1.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
